// File: rtl/cu_dispatch_arbiter.sv
// rtl/cu_dispatch_arbiter.sv - command FIFO with round-robin dispatch to two compute units
// Results return in dispatch order through per-unit holding registers and a 2-entry order queue.
module cu_dispatch_arbiter #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         cmd_valid,
   input  logic [W-1:0] cmd_data,
   output logic         cmd_ready,
   output logic         cu0_start,
   output logic         cu1_start,
   output logic [W-1:0] cu_op,
   input  logic         cu0_busy,
   input  logic         cu1_busy,
   input  logic         cu0_done,
   input  logic         cu1_done,
   input  logic [W-1:0] cu0_result,
   input  logic [W-1:0] cu1_result,
   output logic         res_valid,
   output logic [W-1:0] res_data,
   output logic         res_unit,
   input  logic         res_ready,
   output logic         err
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [1:0]    busy;
   logic [1:0]    done;
   logic [1:0]    out_q;
   logic [1:0]    hold_v;
   logic [1:0]    free;
   logic [W-1:0]  result [2];
   logic [W-1:0]  hold [2];
   logic          rr;
   logic [1:0]    oq;
   logic          oq_wr;
   logic          oq_rd;
   logic [1:0]    oq_cnt;
   logic          full;
   logic          empty;
   logic          push;
   logic          dispatch;
   logic          pick;
   logic          head;
   logic          load;

   assign busy      = {cu1_busy, cu0_busy};
   assign done      = {cu1_done, cu0_done};
   assign result[0] = cu0_result;
   assign result[1] = cu1_result;
   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full && ena;
   assign free      = ~busy & ~out_q & ~hold_v;
   assign dispatch  = ena && !empty && (free != 2'b00);
   assign pick      = (&free) ? rr : free[1];
   assign head      = oq[oq_rd];
   // A unit's result may only leave once it is the oldest dispatch still pending.
   assign load      = (oq_cnt != 2'd0) && hold_v[head] && (!res_valid || res_ready);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rr        <= 1'b0;
         cu0_start <= 1'b0;
         cu1_start <= 1'b0;
         cu_op     <= '0;
      end else begin
         cu0_start <= 1'b0;
         cu1_start <= 1'b0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (dispatch) begin
            rd_ptr    <= rd_ptr + 1'b1;
            cu_op     <= fifo_mem[rd_ptr];
            cu0_start <= !pick;
            cu1_start <= pick;
            rr        <= !pick;
         end
         case ({push, dispatch})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oq        <= 2'b00;
         oq_wr     <= 1'b0;
         oq_rd     <= 1'b0;
         oq_cnt    <= 2'd0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_unit  <= 1'b0;
      end else begin
         if (dispatch) begin
            oq[oq_wr] <= pick;
            oq_wr     <= !oq_wr;
         end
         case ({dispatch, load})
            2'b10:   oq_cnt <= oq_cnt + 2'd1;
            2'b01:   oq_cnt <= oq_cnt - 2'd1;
            default: oq_cnt <= oq_cnt;
         endcase
         if (load) begin
            oq_rd     <= !oq_rd;
            res_data  <= hold[head];
            res_unit  <= head;
            res_valid <= 1'b1;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= 2'b00;
         hold_v <= 2'b00;
         err    <= 1'b0;
         for (int n = 0; n < 2; n++) hold[n] <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (dispatch && pick == 1'(n))
               out_q[n] <= 1'b1;
            else if (done[n] && out_q[n])
               out_q[n] <= 1'b0;
            if (done[n] && out_q[n]) begin
               hold[n]   <= result[n];
               hold_v[n] <= 1'b1;
            end else if (load && head == 1'(n)) begin
               hold_v[n] <= 1'b0;
            end
            // A done with nothing outstanding (including work lost to reset) is flagged.
            if (done[n] && !out_q[n]) err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cu_dispatch_arbiter.sv
// tb/tb_cu_dispatch_arbiter.sv - scoreboard bench for cu_dispatch_arbiter
module tb_cu_dispatch_arbiter;
   localparam int W     = 8;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b1;
   logic         cmd_valid = 1'b0;
   logic [W-1:0] cmd_data = '0;
   logic         cmd_ready;
   logic         cu0_start;
   logic         cu1_start;
   logic [W-1:0] cu_op;
   logic         cu0_busy = 1'b0;
   logic         cu1_busy = 1'b0;
   logic         cu0_done = 1'b0;
   logic         cu1_done = 1'b0;
   logic [W-1:0] cu0_result = '0;
   logic [W-1:0] cu1_result = '0;
   logic         res_valid;
   logic [W-1:0] res_data;
   logic         res_unit;
   logic         res_ready = 1'b0;
   logic         err;

   typedef struct packed {
      logic         unit;
      logic [W-1:0] data;
   } res_t;

   res_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   cu_dispatch_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .cu0_start(cu0_start), .cu1_start(cu1_start), .cu_op(cu_op),
      .cu0_busy(cu0_busy), .cu1_busy(cu1_busy),
      .cu0_done(cu0_done), .cu1_done(cu1_done),
      .cu0_result(cu0_result), .cu1_result(cu1_result),
      .res_valid(res_valid), .res_data(res_data), .res_unit(res_unit),
      .res_ready(res_ready), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input logic u, input logic [W-1:0] d);
      res_t e;
      e.unit = u;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic chk_res(input string tag);
      res_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_data"}, res_data, e.data);
      chk({tag, "_unit"}, res_unit, e.unit);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cu0_done  = 1'b0;
      cu1_done  = 1'b0;
      res_ready = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic push_cmd(input logic [W-1:0] d);
      chk("push_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_data  = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(input logic u);
      int c = 0;
      while (c < 20 && !(u ? cu1_start : cu0_start)) begin
         tick();
         c++;
      end
      chk("start_seen", u ? cu1_start : cu0_start, 1);
   endtask

   task automatic drain(input int n);
      int got = 0;
      res_ready = 1'b1;
      for (int c = 0; c < 40 && got < n; c++) begin
         if (res_valid) begin
            chk_res("drain");
            got++;
         end
         tick();
      end
      res_ready = 1'b0;
      chk("drain_cnt", got, n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int np;
      logic [W-1:0] op;

      // reset state
      do_reset();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_start0", cu0_start, 0);
      chk("rst_cu_op", cu_op, 0);

      // single command
      cmd_valid = 1'b1;
      cmd_data  = 8'h5A;
      tick();
      cmd_valid = 1'b0;
      chk("t1_no_start_yet", cu0_start, 0);
      tick();
      chk("t1_start0", cu0_start, 1);
      chk("t1_start1", cu1_start, 0);
      chk("t1_op", cu_op, 8'h5A);
      tick();
      chk("t1_start_one_cycle", cu0_start, 0);
      chk("t1_op_held", cu_op, 8'h5A);
      sb_push(1'b0, 8'hA5);
      cu0_done = 1'b1; cu0_result = 8'hA5;
      tick();
      cu0_done = 1'b0;
      chk("t1_res_not_yet", res_valid, 0);
      tick();
      chk_res("t1_res");
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("t1_res_cleared", res_valid, 0);

      // round robin
      do_reset();
      cmd_valid = 1'b1;
      cmd_data  = 8'h01;
      tick();
      cmd_data = 8'h02;
      tick();
      cmd_valid = 1'b0;
      chk("rr_start0", cu0_start, 1);
      chk("rr_op0", cu_op, 8'h01);
      tick();
      chk("rr_start1", cu1_start, 1);
      chk("rr_start0_low", cu0_start, 0);
      chk("rr_op1", cu_op, 8'h02);

      // in-order return: unit 1 finishes first
      sb_push(1'b0, 8'h11);
      sb_push(1'b1, 8'h22);
      cu1_done = 1'b1; cu1_result = 8'h22;
      tick();
      cu1_done = 1'b0;
      repeat (3) begin
         chk("ord_wait_unit0", res_valid, 0);
         tick();
      end
      cu0_done = 1'b1; cu0_result = 8'h11;
      tick();
      cu0_done = 1'b0;
      res_ready = 1'b1;
      chk("ord_not_yet", res_valid, 0);
      tick();
      chk_res("ord_first");
      tick();
      chk_res("ord_second");
      tick();
      chk("ord_empty", res_valid, 0);
      res_ready = 1'b0;

      // backpressure and pointer wrap over 10 commands
      do_reset();
      cu0_busy = 1'b1;
      cu1_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_ready", cmd_ready, 1);
         cmd_valid = 1'b1;
         cmd_data  = 8'hA0 + 8'(i);
         tick();
      end
      chk("bp_full", cmd_ready, 0);
      cmd_data = 8'hA4;
      tick();
      chk("bp_still_full", cmd_ready, 0);
      chk("bp_no_start", cu0_start, 0);
      cmd_valid = 1'b0;
      cu0_busy  = 1'b0;
      np = 4;
      for (int k = 0; k < 10; k++) begin
         op = 8'hA0 + 8'(k);
         wait_start(1'b0);
         chk("bp_op", cu_op, op);
         chk("bp_unit1_idle", cu1_start, 0);
         sb_push(1'b0, ~op);
         cu0_done = 1'b1; cu0_result = ~op;
         if (np < 10) begin
            chk("bp_ready_after_pop", cmd_ready, 1);
            cmd_valid = 1'b1;
            cmd_data  = 8'hA0 + 8'(np);
            np++;
         end
         tick();
         cmd_valid = 1'b0;
         cu0_done  = 1'b0;
         drain(1);
      end
      cu1_busy = 1'b0;

      // output stall with unit 0's result held
      do_reset();
      cu0_busy = 1'b1;
      push_cmd(8'h31);
      tick();
      chk("st_start1", cu1_start, 1);
      chk("st_op1", cu_op, 8'h31);
      cu0_busy = 1'b0;
      push_cmd(8'h32);
      tick();
      chk("st_start0", cu0_start, 1);
      chk("st_op0", cu_op, 8'h32);
      sb_push(1'b1, 8'h41);
      sb_push(1'b0, 8'h42);
      cu1_done = 1'b1; cu1_result = 8'h41;
      cu0_done = 1'b1; cu0_result = 8'h42;
      cu1_busy = 1'b1;
      tick();
      cu0_done = 1'b0;
      cu1_done = 1'b0;
      tick();
      push_cmd(8'h33);
      repeat (4) begin
         chk("st_valid", res_valid, 1);
         chk("st_data_fixed", res_data, 8'h41);
         chk("st_no_redispatch0", cu0_start, 0);
         chk("st_no_dispatch1", cu1_start, 0);
         tick();
      end
      res_ready = 1'b1;
      chk_res("st_drain_a");
      tick();
      chk_res("st_drain_b");
      tick();
      res_ready = 1'b0;
      chk("st_drained", res_valid, 0);
      chk("st_redispatch0", cu0_start, 1);
      chk("st_redispatch_op", cu_op, 8'h33);
      cu1_busy = 1'b0;
      sb_push(1'b0, 8'h43);
      cu0_done = 1'b1; cu0_result = 8'h43;
      tick();
      cu0_done = 1'b0;
      drain(1);

      // reset mid-dispatch, then spurious done
      do_reset();
      push_cmd(8'h77);
      tick();
      chk("rs_started", cu0_start, 1);
      rst_n = 1'b0;
      #1;
      chk("rs_start0", cu0_start, 0);
      chk("rs_cu_op", cu_op, 0);
      chk("rs_res_valid", res_valid, 0);
      chk("rs_res_data", res_data, 0);
      chk("rs_res_unit", res_unit, 0);
      chk("rs_cmd_ready", cmd_ready, 1);
      chk("rs_err", err, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rs_no_start", cu0_start, 0);
      cu1_done = 1'b1; cu1_result = 8'h99;
      tick();
      cu1_done = 1'b0;
      chk("sp_err_set", err, 1);
      chk("sp_no_result", res_valid, 0);
      repeat (3) tick();
      chk("sp_err_sticky", err, 1);
      do_reset();
      chk("sp_err_cleared", err, 0);
      chk("sb_empty_end", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cu_dispatch_arbiter.md
# cu_dispatch_arbiter

Shares the two compute units in the chip top between one stream of 8-bit commands from the input pins. Commands are buffered in a FIFO and dispatched round-robin to whichever unit is free, using a start/done handshake. Results are collected and returned over a single valid/ready port, in dispatch order. This block replaces the OR/XOR merge of the unit outputs.

## Interface
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- W, 8: command and result width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  when low, blocks FIFO push and dispatch; everything else keeps running.
- cmd_valid  in  1  command offered.
- cmd_data  in  W  command payload.
- cmd_ready  out  1  combinational; equals !full.
- cu0_start, cu1_start  out  1  one-cycle registered start pulse to unit 0 / unit 1.
- cu_op  out  W  registered operand; valid in the cycle a start is high.
- cu0_busy, cu1_busy  in  1  unit busy.
- cu0_done, cu1_done  in  1  one-cycle completion pulse.
- cu0_result, cu1_result  in  W  result; sampled only in the done cycle.
- res_valid  out  1  result available.
- res_data  out  W  result.
- res_unit  out  1  ID of the unit that produced res_data.
- res_ready  in  1  consumer accepts the result.
- err  out  1  sticky flag: a done arrived with nothing outstanding on that unit.

## Operation
- **Push:** cmd_valid && cmd_ready && ena writes cmd_data at the FIFO tail.
- **Unit N free:** !cuN_busy && !out_N && !hold_v_N.
  - out_N = a command is outstanding on unit N.
  - hold_v_N = the per-unit result holding register is full.
- **Dispatch:** at an edge where ena, FIFO non-empty, and at least one unit is free.
  - Both free: pick unit rr. One free: pick that one.
  - Same edge: cuN_start<=1, cu_op<=head, pop, out_N<=1, rr<=~N, unit ID pushed onto the order queue.
  - At most one dispatch per edge.
- **Order queue:** 2 entries of unit IDs; it can never overflow.
- **cuN_done:**
  - If out_N: hold_N<=cuN_result, hold_v_N<=1, out_N<=0.
  - Otherwise: ignored, and err<=1.
- **Output load:** when order-queue head u has hold_v_u && (!res_valid || res_ready):
  - res_data<=hold_u, res_unit<=u, res_valid<=1.
  - hold_v_u<=0, pop the order queue.
  - If instead res_valid && res_ready with nothing to load, res_valid<=0.
- **Ordering:** results leave strictly in dispatch order. A unit that finishes early waits in its holding register.
- **Simultaneous events:**
  - Push and pop in the same edge leave the count unchanged.
  - cuN_done in the same edge as a dispatch to the other unit: both take effect.
  - Unit N cannot be redispatched until hold_v_N clears.
- **Full/empty:**
  - Full: cmd_ready=0 and the push is dropped (cmd_valid is a no-op).
  - Empty: no dispatch.
  - Pointers wrap modulo DEPTH; count is held in log2(DEPTH)+1 bits.
- **Reset (at any time, including mid-operation):**
  - FIFO and order queue empty; rr=0; out, hold_v, err cleared.
  - cu0_start=cu1_start=0, cu_op=0, res_valid=0, res_data=0, res_unit=0.
  - cmd_ready=1.
  - In-flight unit work is forgotten. A later done counts as spurious and sets err.

## Timing
- Push at edge E → earliest start pulse is high in the cycle after edge E+1.
- Start pulses last exactly one cycle. cu_op holds its value until the next dispatch.
- Done high in cycle D → hold captured at the end of D → res_valid high from cycle D+2, provided the output is free and the unit is at the order-queue head.
- res_valid, res_data and res_unit stay stable until the res_ready handshake completes.
- Back-to-back results are possible every cycle when res_ready=1.
- Full-throughput dispatch: commands go to alternating units on consecutive edges while both units are free.

## Test plan
- **Single command:** reset, then push 0x5A.
  - cu0_start is high for 1 cycle, 2 cycles after the push edge, with cu_op=0x5A.
  - Drive cu0_done with result 0xA5 → res_valid is high 2 cycles later with res_data=0xA5, res_unit=0.
- **Round robin:** push 0x01 and 0x02 back-to-back with both units idle → 0x01 goes to unit 0, then 0x02 to unit 1 on the next edge.
- **In-order return:** unit 1 signals done (0x22) before unit 0 (0x11).
  - Output is 0x11/unit 0, then 0x22/unit 1.
  - res_valid stays low until unit 0's done.
- **Backpressure:** keep both units busy and push 5 commands with DEPTH=4.
  - cmd_ready drops after the 4th push; the 5th is not accepted until a dispatch pops.
  - The FIFO pointers wrap correctly across 10 commands.
- **Output stall:** hold res_ready=0 with two results completed.
  - res_data stays fixed; unit 0 is not redispatched while its result is held.
  - Release res_ready → both results drain on consecutive cycles.
- **Reset/spurious:**
  - Assert rst_n low mid-dispatch → all outputs return to their reset values immediately.
  - Pulse cu1_done afterwards → err=1, and it stays 1 until the next reset.
